// File: rtl/fwrisc_trace_buf.sv
// fwrisc_trace_buf: retirement-trace capture buffer for the fwrisc core.
// Samples pc/instr/rd-write on every enabled instr_complete into a DEPTH-entry
// circular buffer and presents the oldest record on a first-word-fall-through
// valid/ready port. WRAP_MODE selects stop-when-full (drops counted) or
// overwrite-oldest. Define FWRISC_TRACE_MEM_EN to also capture the last data-bus
// beat seen before each retirement (t_m_* outputs).
module fwrisc_trace_buf #(
  parameter int DEPTH     = 16,
  parameter int WRAP_MODE = 0,
  parameter int DROP_W    = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       clear,
  input  logic                       instr_complete,
  input  logic [31:0]                pc,
  input  logic [31:0]                instr,
  input  logic                       rd_wen,
  input  logic [5:0]                 rd_waddr,
  input  logic [31:0]                rd_wdata,
  input  logic                       mvalid,
  input  logic [31:0]                maddr,
  input  logic [31:0]                mdata,
  input  logic                       mwrite,
  output logic                       t_valid,
  input  logic                       t_ready,
  output logic [31:0]                t_pc,
  output logic [31:0]                t_instr,
  output logic                       t_rd_wen,
  output logic [5:0]                 t_rd_waddr,
  output logic [31:0]                t_rd_wdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count
`ifdef FWRISC_TRACE_MEM_EN
  ,
  output logic                       t_m_vld,
  output logic [31:0]                t_m_addr,
  output logic [31:0]                t_m_data,
  output logic                       t_m_write
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

  typedef struct packed {
`ifdef FWRISC_TRACE_MEM_EN
    logic        m_vld;
    logic [31:0] m_addr;
    logic [31:0] m_data;
    logic        m_write;
`endif
    logic [31:0] pc;
    logic [31:0] instr;
    logic        rd_wen;
    logic [5:0]  rd_waddr;
    logic [31:0] rd_wdata;
  } entry_t;

  entry_t entry_mem [DEPTH];
  entry_t wr_entry;
  entry_t head_entry;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_count_q, drop_count_d;

  logic push;
  logic pop;
  logic full;
  logic mem_we;

  assign push = instr_complete && enable;
  assign pop  = (count_q != '0) && t_ready;
  assign full = (count_q == FULL_CNT);

`ifdef FWRISC_TRACE_MEM_EN
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [31:0] pend_data_q, pend_data_d;
  logic        pend_write_q, pend_write_d;

  // Pending beat: keep the last mvalid beat, consumed by the next retirement.
  always_comb begin
    pend_vld_d   = pend_vld_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    pend_write_d = pend_write_q;
    if (clear || push) begin
      pend_vld_d   = 1'b0;
      pend_addr_d  = '0;
      pend_data_d  = '0;
      pend_write_d = 1'b0;
    end else if (mvalid) begin
      pend_vld_d   = 1'b1;
      pend_addr_d  = maddr;
      pend_data_d  = mdata;
      pend_write_d = mwrite;
    end
  end

  // Pending beat register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_vld_q   <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      pend_write_q <= 1'b0;
    end else begin
      pend_vld_q   <= pend_vld_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      pend_write_q <= pend_write_d;
    end
  end
`else
  // The data-bus inputs stay on the port list so the core hookup is identical
  // in both builds; they are simply sunk here.
  logic unused_mem;
  assign unused_mem = ^{mvalid, maddr, mdata, mwrite};
`endif

  // Assemble the record to store; register fields read 0 when rd_wen is low.
  always_comb begin
    wr_entry          = '0;
    wr_entry.pc       = pc;
    wr_entry.instr    = instr;
    wr_entry.rd_wen   = rd_wen;
    wr_entry.rd_waddr = rd_wen ? rd_waddr : 6'd0;
    wr_entry.rd_wdata = rd_wen ? rd_wdata : 32'd0;
`ifdef FWRISC_TRACE_MEM_EN
    // A beat in the retiring cycle wins over an older pending one.
    if (mvalid) begin
      wr_entry.m_vld   = 1'b1;
      wr_entry.m_addr  = maddr;
      wr_entry.m_data  = mdata;
      wr_entry.m_write = mwrite;
    end else begin
      wr_entry.m_vld   = pend_vld_q;
      wr_entry.m_addr  = pend_addr_q;
      wr_entry.m_data  = pend_data_q;
      wr_entry.m_write = pend_write_q;
    end
`endif
  end

  // Pointer / occupancy / status next-state; clear overrides push and pop.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    mem_we       = 1'b0;
    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end else if (push && pop) begin
      // Includes the full case: the popped slot is the one being refilled.
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else if (push && !full) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      count_d  = count_q + CNT_ONE;
    end else if (push) begin
      overflow_d = 1'b1;
      if (WRAP_MODE == 1) begin
        // wr_ptr == rd_ptr when full, so this replaces the oldest record.
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else if (drop_count_q != '1) begin
        drop_count_d = drop_count_q + DROP_ONE;
      end
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d  = count_q - CNT_ONE;
    end
  end

  // Control and status registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Record storage; no reset so it maps onto distributed/block RAM.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      entry_mem[wr_ptr_q] <= wr_entry;
    end
  end

  // Head entry falls through from storage; masked to 0 while empty.
  assign head_entry = entry_mem[rd_ptr_q];
  assign t_valid    = (count_q != '0);
  assign t_pc       = t_valid ? head_entry.pc       : 32'd0;
  assign t_instr    = t_valid ? head_entry.instr    : 32'd0;
  assign t_rd_wen   = t_valid ? head_entry.rd_wen   : 1'b0;
  assign t_rd_waddr = t_valid ? head_entry.rd_waddr : 6'd0;
  assign t_rd_wdata = t_valid ? head_entry.rd_wdata : 32'd0;
`ifdef FWRISC_TRACE_MEM_EN
  assign t_m_vld    = t_valid ? head_entry.m_vld    : 1'b0;
  assign t_m_addr   = t_valid ? head_entry.m_addr   : 32'd0;
  assign t_m_data   = t_valid ? head_entry.m_data   : 32'd0;
  assign t_m_write  = t_valid ? head_entry.m_write  : 1'b0;
`endif

  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_fwrisc_trace_buf.sv
// tb_fwrisc_trace_buf: directed bench for fwrisc_trace_buf. Two instances share
// the same stimulus: dut_a in stop-when-full mode, dut_b in overwrite mode.
module tb_fwrisc_trace_buf;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        clear;
  logic        instr_complete;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        rd_wen;
  logic [5:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        mvalid;
  logic [31:0] maddr;
  logic [31:0] mdata;
  logic        mwrite;
  logic        t_ready;

  logic        a_t_valid, b_t_valid;
  logic [31:0] a_t_pc, b_t_pc;
  logic [31:0] a_t_instr, b_t_instr;
  logic        a_t_rd_wen, b_t_rd_wen;
  logic [5:0]  a_t_rd_waddr, b_t_rd_waddr;
  logic [31:0] a_t_rd_wdata, b_t_rd_wdata;
  logic [4:0]  a_count, b_count;
  logic        a_overflow, b_overflow;
  logic [15:0] a_drop, b_drop;
`ifdef FWRISC_TRACE_MEM_EN
  logic        a_t_m_vld, b_t_m_vld;
  logic [31:0] a_t_m_addr, b_t_m_addr;
  logic [31:0] a_t_m_data, b_t_m_data;
  logic        a_t_m_write, b_t_m_write;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clock = ~clock;

  fwrisc_trace_buf #(.DEPTH(16), .WRAP_MODE(0), .DROP_W(16)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .instr_complete(instr_complete), .pc(pc), .instr(instr),
    .rd_wen(rd_wen), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
    .mvalid(mvalid), .maddr(maddr), .mdata(mdata), .mwrite(mwrite),
    .t_valid(a_t_valid), .t_ready(t_ready), .t_pc(a_t_pc), .t_instr(a_t_instr),
    .t_rd_wen(a_t_rd_wen), .t_rd_waddr(a_t_rd_waddr), .t_rd_wdata(a_t_rd_wdata),
    .count(a_count), .overflow(a_overflow), .drop_count(a_drop)
`ifdef FWRISC_TRACE_MEM_EN
    , .t_m_vld(a_t_m_vld), .t_m_addr(a_t_m_addr), .t_m_data(a_t_m_data), .t_m_write(a_t_m_write)
`endif
  );

  fwrisc_trace_buf #(.DEPTH(16), .WRAP_MODE(1), .DROP_W(16)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .instr_complete(instr_complete), .pc(pc), .instr(instr),
    .rd_wen(rd_wen), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
    .mvalid(mvalid), .maddr(maddr), .mdata(mdata), .mwrite(mwrite),
    .t_valid(b_t_valid), .t_ready(t_ready), .t_pc(b_t_pc), .t_instr(b_t_instr),
    .t_rd_wen(b_t_rd_wen), .t_rd_waddr(b_t_rd_waddr), .t_rd_wdata(b_t_rd_wdata),
    .count(b_count), .overflow(b_overflow), .drop_count(b_drop)
`ifdef FWRISC_TRACE_MEM_EN
    , .t_m_vld(b_t_m_vld), .t_m_addr(b_t_m_addr), .t_m_data(b_t_m_data), .t_m_write(b_t_m_write)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, act);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_push(input logic [31:0] p, input logic [31:0] ins,
                         input logic we, input logic [5:0] wa, input logic [31:0] wd);
    instr_complete = 1'b1;
    pc       = p;
    instr    = ins;
    rd_wen   = we;
    rd_waddr = wa;
    rd_wdata = wd;
    tick();
    instr_complete = 1'b0;
  endtask

  task automatic pop_one();
    t_ready = 1'b1;
    tick();
    t_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; clear = 1'b0; instr_complete = 1'b0;
    pc = '0; instr = '0; rd_wen = 1'b0; rd_waddr = '0; rd_wdata = '0;
    mvalid = 1'b0; maddr = '0; mdata = '0; mwrite = 1'b0; t_ready = 1'b0;

    // Reset state, both while held and after release
    repeat (3) tick();
    check_val("rst_hold_valid", 32'(a_t_valid), 32'd0);
    check_val("rst_hold_count", 32'(a_count), 32'd0);
    check_val("rst_hold_pc", a_t_pc, 32'd0);
    reset = 1'b1;
    tick();
    check_val("rst_valid", 32'(a_t_valid), 32'd0);
    check_val("rst_count", 32'(a_count), 32'd0);
    check_val("rst_overflow", 32'(a_overflow), 32'd0);
    check_val("rst_drop", 32'(a_drop), 32'd0);

    // Basic push, visible the cycle after the edge
    do_push(32'h100, 32'h0050_0093, 1'b1, 6'd1, 32'd5);
    check_val("basic_valid", 32'(a_t_valid), 32'd1);
    check_val("basic_pc", a_t_pc, 32'h100);
    check_val("basic_instr", a_t_instr, 32'h0050_0093);
    check_val("basic_rd_wen", 32'(a_t_rd_wen), 32'd1);
    check_val("basic_waddr", 32'(a_t_rd_waddr), 32'd1);
    check_val("basic_wdata", a_t_rd_wdata, 32'd5);
    check_val("basic_count", 32'(a_count), 32'd1);
    check_val("basic_b_pc", b_t_pc, 32'h100);
    pop_one();
    check_val("pop_count", 32'(a_count), 32'd0);
    check_val("pop_valid", 32'(a_t_valid), 32'd0);
    check_val("pop_pc_masked", a_t_pc, 32'd0);

    // Pop while empty is ignored
    t_ready = 1'b1;
    tick();
    tick();
    t_ready = 1'b0;
    check_val("empty_pop_a", 32'(a_count), 32'd0);
    check_val("empty_pop_b", 32'(b_count), 32'd0);

    // rd_wen=0 zeroes stored register fields
    do_push(32'h104, 32'h0000_0013, 1'b0, 6'd7, 32'h55);
    check_val("nowen_pc", a_t_pc, 32'h104);
    check_val("nowen_waddr", 32'(a_t_rd_waddr), 32'd0);
    check_val("nowen_wdata", a_t_rd_wdata, 32'd0);
    pop_one();

    // Fill with 20 records, pc = 4*i, no host reads
    for (int i = 0; i < 20; i++) begin
      do_push(32'(4 * i), 32'(i), 1'b1, 6'(i), 32'(i + 32'h1000));
    end
    check_val("fill_a_count", 32'(a_count), 32'd16);
    check_val("fill_a_drop", 32'(a_drop), 32'd4);
    check_val("fill_a_ovf", 32'(a_overflow), 32'd1);
    check_val("fill_b_count", 32'(b_count), 32'd16);
    check_val("fill_b_drop", 32'(b_drop), 32'd0);
    check_val("fill_b_ovf", 32'(b_overflow), 32'd1);

    // Head holds while not accepted
    tick();
    check_val("hold_a_pc", a_t_pc, 32'd0);
    check_val("hold_b_pc", b_t_pc, 32'd16);
    check_val("hold_b_instr", b_t_instr, 32'd4);

    // Drain: stop mode keeps pushes 1..16, overwrite mode keeps 5..20
    t_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_val($sformatf("drain_a_pc%0d", i), a_t_pc, 32'(4 * i));
      check_val($sformatf("drain_b_pc%0d", i), b_t_pc, 32'(4 * (i + 4)));
      tick();
    end
    t_ready = 1'b0;
    check_val("drained_a_count", 32'(a_count), 32'd0);
    check_val("drained_b_count", 32'(b_count), 32'd0);
    check_val("sticky_a_ovf", 32'(a_overflow), 32'd1);
    check_val("sticky_a_drop", 32'(a_drop), 32'd4);

    // Refill exactly to DEPTH, then push+pop at full
    for (int i = 0; i < 16; i++) begin
      do_push(32'(32'h200 + 4 * i), 32'(i), 1'b1, 6'd2, 32'(i));
    end
    check_val("refill_a_count", 32'(a_count), 32'd16);
    check_val("refill_a_drop", 32'(a_drop), 32'd4);
    t_ready = 1'b1;
    do_push(32'h300, 32'h1, 1'b1, 6'd3, 32'h3);
    t_ready = 1'b0;
    check_val("simul_a_count", 32'(a_count), 32'd16);
    check_val("simul_a_drop", 32'(a_drop), 32'd4);
    check_val("simul_a_head", a_t_pc, 32'h204);
    check_val("simul_b_count", 32'(b_count), 32'd16);
    check_val("simul_b_head", b_t_pc, 32'h204);

    // Clear wins over a same-cycle push
    clear = 1'b1;
    do_push(32'h400, 32'h2, 1'b1, 6'd4, 32'h4);
    clear = 1'b0;
    check_val("clear_a_count", 32'(a_count), 32'd0);
    check_val("clear_a_ovf", 32'(a_overflow), 32'd0);
    check_val("clear_a_drop", 32'(a_drop), 32'd0);
    check_val("clear_a_valid", 32'(a_t_valid), 32'd0);
    check_val("clear_b_count", 32'(b_count), 32'd0);
    check_val("clear_b_ovf", 32'(b_overflow), 32'd0);

    // Disabled retirements are neither stored nor counted as drops
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_push(32'(32'h500 + 4 * i), 32'h3, 1'b1, 6'd5, 32'h5);
    end
    enable = 1'b1;
    check_val("dis_a_count", 32'(a_count), 32'd0);
    check_val("dis_a_drop", 32'(a_drop), 32'd0);

    // After clear the buffer restarts cleanly
    do_push(32'h600, 32'h4, 1'b1, 6'd6, 32'h6);
    check_val("post_clear_pc", a_t_pc, 32'h600);
    check_val("post_clear_count", 32'(a_count), 32'd1);
    pop_one();

`ifdef FWRISC_TRACE_MEM_EN
    // Beat two cycles before retirement is attached to that record
    mvalid = 1'b1; maddr = 32'h2000; mdata = 32'hDEAD_BEEF; mwrite = 1'b1;
    tick();
    mvalid = 1'b0; maddr = '0; mdata = '0; mwrite = 1'b0;
    tick();
    do_push(32'h700, 32'h5, 1'b1, 6'd7, 32'h7);
    check_val("mem_vld", 32'(a_t_m_vld), 32'd1);
    check_val("mem_addr", a_t_m_addr, 32'h2000);
    check_val("mem_data", a_t_m_data, 32'hDEAD_BEEF);
    check_val("mem_write", 32'(a_t_m_write), 32'd1);
    pop_one();
    // Pending beat was consumed
    do_push(32'h704, 32'h6, 1'b1, 6'd8, 32'h8);
    check_val("mem_none_vld", 32'(a_t_m_vld), 32'd0);
    check_val("mem_none_addr", a_t_m_addr, 32'd0);
    pop_one();
    // Same-cycle beat overrides an older pending beat
    mvalid = 1'b1; maddr = 32'h1111; mdata = 32'h2222; mwrite = 1'b1;
    tick();
    maddr = 32'h3000; mdata = 32'h1234_5678; mwrite = 1'b0;
    do_push(32'h708, 32'h7, 1'b1, 6'd9, 32'h9);
    mvalid = 1'b0; maddr = '0; mdata = '0;
    check_val("mem_same_vld", 32'(b_t_m_vld), 32'd1);
    check_val("mem_same_addr", b_t_m_addr, 32'h3000);
    check_val("mem_same_data", b_t_m_data, 32'h1234_5678);
    check_val("mem_same_write", 32'(b_t_m_write), 32'd0);
    pop_one();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
